// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : imem_fetch
//  Purpose  : Instruction-fetch front end. Owns the byte PC, drives the imem
//             word address, and registers each returned word into a one-entry
//             valid/ready buffer toward decode. Supports branch redirect,
//             stall back-pressure and wrap across the imem address space.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk          in   1       rising-edge clock
//    reset        in   1       synchronous, active-high reset
//    imem_addr    out  ADDR_W  word address to imem (from PC register)
//    imem_q       in   32      imem read data (combinational, same cycle)
//    instr        out  32      buffered instruction
//    instr_pc     out  N       byte PC of instr
//    instr_valid  out  1       instr/instr_pc valid
//    instr_ready  in   1       decode accepts when instr_valid & instr_ready
//    redirect     in   1       load redirect_pc as next fetch PC
//    redirect_pc  in   N       target byte address (bits [1:0] ignored)
//    pc_out       out  N       current fetch PC
//    halt         out  1       fetch stopped on a zero word
//
//  Build option
//    FETCH_HALT_EN : when defined, a fetched all-zero word halts fetch
//                    (sticky until reset). When undefined, zero words stream
//                    normally and halt is tied low.
// ============================================================================
module imem_fetch #(
  parameter int N      = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_q,
  output logic [31:0]       instr,
  output logic [N-1:0]      instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [N-1:0]      redirect_pc,
  output logic [N-1:0]      pc_out,
  output logic              halt
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
`ifdef FETCH_HALT_EN
  localparam logic [1:0] HALTED = 2'd2;
`endif

  localparam logic [N-1:0] PC_STEP = N'(4);

  logic [1:0]   state;
  logic [N-1:0] pc;
  logic         load;

  // The low two bits of the redirect target are discarded (word alignment).
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pc_out    = pc;
  assign imem_addr = pc[ADDR_W+1:2];

  // HOLD always carries a valid word, so in HOLD this reduces to instr_ready;
  // in FETCH an empty buffer refills unconditionally.
  assign load = instr_ready | ((state == FETCH) & ~instr_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      state       <= FETCH;
`ifdef FETCH_HALT_EN
      halt        <= 1'b0;
`endif
    end
`ifdef FETCH_HALT_EN
    else if (state == HALTED) begin
      // Sticky: only reset leaves this state; redirect is ignored.
      instr_valid <= 1'b0;
      halt        <= 1'b1;
    end
`endif
    else if (redirect) begin
      // Any word in the buffer is either being consumed this edge or is
      // stale; in both cases it is dropped and fetch restarts at the target.
      pc          <= {redirect_pc[N-1:2], 2'b00};
      instr_valid <= 1'b0;
      state       <= FETCH;
    end else if (load) begin
`ifdef FETCH_HALT_EN
      if (imem_q == 32'h0000_0000) begin
        // pc stays on the zero word's address.
        instr_valid <= 1'b0;
        halt        <= 1'b1;
        state       <= HALTED;
      end else
`endif
      begin
        instr       <= imem_q;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + PC_STEP;
        state       <= FETCH;
      end
    end else begin
      // Valid word not accepted: everything freezes.
      state <= HOLD;
    end
  end

`ifndef FETCH_HALT_EN
  assign halt = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_fetch
//  Purpose  : Self-checking bench for imem_fetch with a behavioural imem and
//             a transaction-level reference model of the fetch stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] pc_out;
  logic        halt;

  logic [31:0] mem [64];

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  assign imem_q = mem[imem_addr];

  imem_fetch #(.N(64), .ADDR_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_out      (pc_out),
    .halt        (halt)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
  endtask

  task automatic load_program();
    for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
    mem[6'h00] = 32'hf800_0001;
    mem[6'h01] = 32'hf800_8002;
    mem[6'h02] = 32'hf800_0203;
    mem[6'h03] = 32'h8b05_0083;
    mem[6'h1D] = 32'hf800_0003;
    mem[6'h2E] = 32'hb400_001f;
    for (int i = 6'h2F; i <= 6'h3F; i++) mem[i] = 32'h0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({instr_valid, instr, instr_pc, pc_out, halt, imem_addr} !== '0) begin
      failed++;
      $display("FAIL reset_values: valid=%b instr=%h ipc=%h pc=%h halt=%b addr=%h (all zero required)",
               instr_valid, instr, instr_pc, pc_out, halt, imem_addr);
    end
  endtask

  task automatic test_stream_and_stall();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'hf800_0001; exp_w[1] = 32'hf800_8002;
    exp_w[2] = 32'hf800_0203; exp_w[3] = 32'h8b05_0083;
    do_reset();
    reset = 1'b0;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if ({instr_valid, instr, instr_pc, pc_out} !== {1'b1, exp_w[k], 64'(4*k), 64'(4*k+4)}) begin
        failed++;
        $display("FAIL stream_w%0d: valid=%b instr=%h ipc=%h pc=%h want 1 %h %h %h",
                 k, instr_valid, instr, instr_pc, pc_out, exp_w[k], 4*k, 4*k+4);
      end
    end
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if ({instr_valid, instr, instr_pc, pc_out, imem_addr} !==
          {1'b1, 32'hf800_0203, 64'h8, 64'hC, 6'h3}) begin
        failed++;
        $display("FAIL stall_hold%0d: valid=%b instr=%h ipc=%h pc=%h addr=%h want 1 f8000203 8 c 3",
                 k, instr_valid, instr, instr_pc, pc_out, imem_addr);
      end
    end
    instr_ready = 1'b1;
    tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc, pc_out} !== {1'b1, exp_w[3], 64'hC, 64'h10}) begin
      failed++;
      $display("FAIL stall_release: valid=%b instr=%h ipc=%h pc=%h want 1 8b050083 c 10",
               instr_valid, instr, instr_pc, pc_out);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    reset = 1'b0;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h76;
    tick();
    redirect = 1'b0;
    tests_run++;
    if ({instr_valid, pc_out, imem_addr} !== {1'b0, 64'h74, 6'h1D}) begin
      failed++;
      $display("FAIL redirect_flush: valid=%b pc=%h addr=%h want 0 74 1d", instr_valid, pc_out, imem_addr);
    end
    instr_ready = 1'b1;
    tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hf800_0003, 64'h74}) begin
      failed++;
      $display("FAIL redirect_target: valid=%b instr=%h ipc=%h want 1 f8000003 74", instr_valid, instr, instr_pc);
    end
    // Redirect together with an accept: word at 0x74 is consumed, then flush.
    redirect    = 1'b1;
    redirect_pc = 64'h8;
    tick();
    redirect = 1'b0;
    tests_run++;
    if ({instr_valid, pc_out} !== {1'b0, 64'h8}) begin
      failed++;
      $display("FAIL redirect_accept_flush: valid=%b pc=%h want 0 8", instr_valid, pc_out);
    end
    tick();
    tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h8b05_0083, 64'hC}) begin
      failed++;
      $display("FAIL redirect_accept_next: valid=%b instr=%h ipc=%h want 1 8b050083 c", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    reset = 1'b0;
    instr_ready = 1'b1;
    tick();
    tick();
    instr_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc, pc_out, halt} !== '0) begin
      failed++;
      $display("FAIL reset_mid_hold: valid=%b instr=%h ipc=%h pc=%h halt=%b want all 0",
               instr_valid, instr, instr_pc, pc_out, halt);
    end
    reset = 1'b0;
    instr_ready = 1'b1;
    tick();
    tests_run++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hf800_0001, 64'h0}) begin
      failed++;
      $display("FAIL restart_after_reset: valid=%b instr=%h ipc=%h want 1 f8000001 0", instr_valid, instr, instr_pc);
    end
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    logic [31:0] last_w  = '0;
    logic [63:0] last_pc = '0;
    int guard = 0;
    do_reset();
    reset = 1'b0;
    instr_ready = 1'b1;
    while (!halt && guard < 200) begin
      tick();
      guard++;
      if (instr_valid) begin
        last_w  = instr;
        last_pc = instr_pc;
      end
    end
    tests_run++;
    if ({halt, instr_valid, pc_out, last_w, last_pc} !== {1'b1, 1'b0, 64'hBC, 32'hb400_001f, 64'hB8}) begin
      failed++;
      $display("FAIL halt_entry: halt=%b valid=%b pc=%h last=%h@%h want 1 0 bc b400001f@b8",
               halt, instr_valid, pc_out, last_w, last_pc);
    end
    redirect    = 1'b1;
    redirect_pc = 64'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if ({halt, instr_valid, pc_out} !== {1'b1, 1'b0, 64'hBC}) begin
        failed++;
        $display("FAIL halt_sticky%0d: halt=%b valid=%b pc=%h want 1 0 bc", k, halt, instr_valid, pc_out);
      end
    end
    redirect = 1'b0;
  endtask
`else
  task automatic test_wrap();
    do_reset();
    reset = 1'b0;
    instr_ready = 1'b1;
    for (int k = 0; k < 70; k++) begin
      tick();
      tests_run++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, mem[k % 64], 64'(4*k)}) begin
        failed++;
        $display("FAIL wrap_word%0d: valid=%b instr=%h ipc=%h want 1 %h %h",
                 k, instr_valid, instr, instr_pc, mem[k % 64], 4*k);
      end
      if (k >= 'h2F && k <= 'h3F) begin
        tests_run++;
        if ({instr_valid, instr} !== {1'b1, 32'h0}) begin
          failed++;
          $display("FAIL zero_word%0d: valid=%b instr=%h want 1 0", k, instr_valid, instr);
        end
      end
      if (k == 63) begin
        tests_run++;
        if ({pc_out, imem_addr} !== {64'h100, 6'h0}) begin
          failed++;
          $display("FAIL wrap_addr: pc=%h addr=%h want 100 0", pc_out, imem_addr);
        end
      end
      if (k == 64) begin
        tests_run++;
        if ({instr, instr_pc} !== {32'hf800_0001, 64'h100}) begin
          failed++;
          $display("FAIL wrap_word64: instr=%h ipc=%h want f8000001 100", instr, instr_pc);
        end
      end
    end
  endtask

  // Transaction model: decode sees consecutive words from exp_pc; a redirect
  // restarts the stream at the aligned target after the current accept.
  task automatic test_random();
    logic [63:0] exp_pc = '0;
    logic [63:0] tgt;
    logic        r, rd;
    logic        first = 1'b1;
    logic        p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0;
    logic [31:0] p_instr = '0;
    logic [63:0] p_ipc = '0, p_tgt = '0;
    do_reset();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!first) begin
        tests_run++;
        if (p_redir) begin
          if ({instr_valid, pc_out} !== {1'b0, p_tgt & ~64'h3}) begin
            failed++;
            $display("FAIL rnd_redirect c%0d: valid=%b pc=%h want 0 %h", c, instr_valid, pc_out, p_tgt & ~64'h3);
          end
        end else if (p_valid && !p_ready) begin
          if ({instr_valid, instr, instr_pc} !== {1'b1, p_instr, p_ipc}) begin
            failed++;
            $display("FAIL rnd_hold c%0d: valid=%b instr=%h ipc=%h want 1 %h %h",
                     c, instr_valid, instr, instr_pc, p_instr, p_ipc);
          end
        end else if (instr_valid !== 1'b1) begin
          failed++;
          $display("FAIL rnd_refill c%0d: valid=%b want 1", c, instr_valid);
        end
      end
      first = 1'b0;
      r  = ($urandom % 10) < 7;
      rd = ($urandom % 20) == 0;
      if (($urandom % 4) == 0) tgt = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom % 256);
      else                     tgt = {$urandom, $urandom};
      instr_ready = r;
      redirect    = rd;
      redirect_pc = tgt;
      if (instr_valid && r) begin
        tests_run++;
        if ({instr, instr_pc} !== {mem[exp_pc[7:2]], exp_pc}) begin
          failed++;
          $display("FAIL rnd_accept c%0d: instr=%h ipc=%h want %h %h", c, instr, instr_pc, mem[exp_pc[7:2]], exp_pc);
        end
        exp_pc = exp_pc + 64'd4;
      end
      if (rd) exp_pc = tgt & ~64'h3;
      p_valid = instr_valid; p_ready = r; p_redir = rd;
      p_instr = instr; p_ipc = instr_pc; p_tgt = tgt;
      tick();
    end
    redirect    = 1'b0;
    instr_ready = 1'b0;
  endtask
`endif

  initial begin
    reset       = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    load_program();
    test_reset();
    test_stream_and_stall();
    test_redirect();
    test_reset_mid_hold();
`ifdef FETCH_HALT_EN
    test_halt();
`else
    test_wrap();
    test_random();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d failed=%0d", tests_run, failed);
    $fatal(1);
  end

endmodule
`default_nettype wire
